// File: rtl/cpu_pkg.sv
// Shared types for the dual-lane memory sequencer: FSM encoding and per-lane op payload.
package cpu_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2,
      DONE = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              need;
   } lane_op_t;

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts cycles an access waits for mem_ready; flags expiry on the MAX_WAIT-th waiting cycle.
module mem_wait_watchdog #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic ready,
   output logic expire
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (!ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // A ready on the final waiting cycle still wins over expiry.
   always_comb begin
      expire = !ready && (cnt_q == CNT_W'(MAX_WAIT - 1));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dual_lane_mem_sequencer.sv
// Serialises the two lanes' memory ops of one issue bundle onto a single-port memory,
// lane 1 first, stalling the front end and returning both load results together.
module dual_lane_mem_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bundle_valid,
   input  logic              memread1,
   input  logic              memwrite1,
   input  logic              memread2,
   input  logic              memwrite2,
   input  logic [DATA_W-1:0] addr1,
   input  logic [DATA_W-1:0] addr2,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              bundle_done,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              timeout_err
);

   localparam int unsigned LANE_W = cpu_pkg::DATA_W;

   seq_state_e        state_q, state_d;
   lane_op_t          lane1_q, lane1_d;
   lane_op_t          lane2_q, lane2_d;
   lane_op_t          sel;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [DATA_W-1:0] rdata2_q, rdata2_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic              bundle_done_q, bundle_done_d;
   logic              timeout_err_q, timeout_err_d;
   logic              need1, need2;
   logic              in_acc;
   logic              wd_clear;
   logic              wd_expire;

   assign need1 = memread1 | memwrite1;
   assign need2 = memread2 | memwrite2;

   mem_wait_watchdog #(
      .MAX_WAIT (MAX_WAIT)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .ready  (mem_ready),
      .expire (wd_expire)
   );

   always_comb begin
      state_d       = state_q;
      lane1_d       = lane1_q;
      lane2_d       = lane2_q;
      rdata1_d      = rdata1_q;
      rdata2_d      = rdata2_q;
      timeout_err_d = timeout_err_q;
      stall         = 1'b0;
      in_acc        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bundle_valid && (need1 || need2)) begin
               stall    = 1'b1;
               lane1_d  = '{we: memwrite1, addr: LANE_W'(addr1), wdata: LANE_W'(wdata1), need: need1};
               lane2_d  = '{we: memwrite2, addr: LANE_W'(addr2), wdata: LANE_W'(wdata2), need: need2};
               rdata1_d = '0;
               rdata2_d = '0;
               state_d  = need1 ? ACC1 : ACC2;
            end
         end
         ACC1: begin
            stall  = 1'b1;
            in_acc = 1'b1;
            if (mem_ready) begin
               if (!lane1_q.we) begin
                  rdata1_d = mem_rdata;
               end
               state_d = lane2_q.need ? ACC2 : DONE;
            end else if (wd_expire) begin
               timeout_err_d = 1'b1;
               state_d       = DONE;
            end
         end
         ACC2: begin
            stall  = 1'b1;
            in_acc = 1'b1;
            if (mem_ready) begin
               if (!lane2_q.we) begin
                  rdata2_d = mem_rdata;
               end
               state_d = DONE;
            end else if (wd_expire) begin
               timeout_err_d = 1'b1;
               state_d       = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Counter restarts whenever a new access begins or none is in flight.
      wd_clear = !in_acc || (state_d != state_q);

      // Bus outputs are registered from the state being entered and the freshly latched lanes.
      sel           = (state_d == ACC2) ? lane2_d : lane1_d;
      mem_req_d     = (state_d == ACC1) || (state_d == ACC2);
      mem_we_d      = mem_req_d && sel.we;
      mem_addr_d    = mem_req_d ? DATA_W'(sel.addr) : mem_addr_q;
      mem_wdata_d   = mem_req_d ? DATA_W'(sel.wdata) : mem_wdata_q;
      bundle_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         lane1_q       <= '0;
         lane2_q       <= '0;
         rdata1_q      <= '0;
         rdata2_q      <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         bundle_done_q <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lane1_q       <= lane1_d;
         lane2_q       <= lane2_d;
         rdata1_q      <= rdata1_d;
         rdata2_q      <= rdata2_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         bundle_done_q <= bundle_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign bundle_done = bundle_done_q;
   assign rdata1      = rdata1_q;
   assign rdata2      = rdata2_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dual_lane_mem_sequencer.sv
// Directed bench for dual_lane_mem_sequencer with a small memory model of configurable latency.
module tb_dual_lane_mem_sequencer;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_WAIT = 15;

   logic              clk;
   logic              reset;
   logic              bundle_valid;
   logic              memread1, memwrite1, memread2, memwrite2;
   logic [DATA_W-1:0] addr1, addr2, wdata1, wdata2;
   logic              mem_req, mem_we;
   logic [DATA_W-1:0] mem_addr, mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall, bundle_done;
   logic [DATA_W-1:0] rdata1, rdata2;
   logic              timeout_err;

   dual_lane_mem_sequencer #(
      .DATA_W   (DATA_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bundle_valid (bundle_valid),
      .memread1     (memread1),
      .memwrite1    (memwrite1),
      .memread2     (memread2),
      .memwrite2    (memwrite2),
      .addr1        (addr1),
      .addr2        (addr2),
      .wdata1       (wdata1),
      .wdata2       (wdata2),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .stall        (stall),
      .bundle_done  (bundle_done),
      .rdata1       (rdata1),
      .rdata2       (rdata2),
      .timeout_err  (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mem [0:1023];
   int          lat;
   int          age;
   int          stall_cnt, req_cnt, done_cnt, acc_n;
   logic [31:0] acc_we [4];
   logic [31:0] acc_addr [4];
   logic [31:0] acc_wdata [4];
   logic [31:0] cap_r1, cap_r2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      stall_cnt = 0;
      req_cnt   = 0;
      done_cnt  = 0;
      acc_n     = 0;
      for (int i = 0; i < 4; i++) begin
         acc_we[i]    = '0;
         acc_addr[i]  = '0;
         acc_wdata[i] = '0;
      end
   endtask

   task automatic drive(input logic v, input logic r1, input logic w1, input logic r2, input logic w2,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic [31:0] a2, input logic [31:0] d2);
      bundle_valid = v;
      memread1     = r1;
      memwrite1    = w1;
      memread2     = r2;
      memwrite2    = w2;
      addr1        = a1;
      wdata1       = d1;
      addr2        = a2;
      wdata2       = d2;
   endtask

   // Called at a falling edge: answers the bus for the coming rising edge and tallies outputs.
   task automatic sample();
      #1;
      if (mem_req) begin
         mem_ready = (lat != 0) && (age == lat - 1);
         mem_rdata = mem[mem_addr[11:2]];
         if (mem_ready) begin
            if (acc_n < 4) begin
               acc_we[acc_n]    = {31'd0, mem_we};
               acc_addr[acc_n]  = mem_addr;
               acc_wdata[acc_n] = mem_wdata;
            end
            acc_n++;
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            age = 0;
         end else begin
            age++;
         end
      end else begin
         mem_ready = 1'b0;
         age       = 0;
      end
      if (stall)       stall_cnt++;
      if (mem_req)     req_cnt++;
      if (bundle_done) done_cnt++;
   endtask

   task automatic advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_bundle(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         sample();
         if (bundle_done) begin
            cap_r1 = rdata1;
            cap_r2 = rdata2;
            seen   = 1'b1;
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
            advance();
            break;
         end
         advance();
      end
      if (!seen) chk({tag, "_done_budget"}, 32'd0, 32'd1);
      for (int i = 0; i < 2; i++) begin
         sample();
         advance();
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[64] = 32'hDEAD_BEEF;
      lat       = 1;
      age       = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      reset     = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_done", {31'd0, bundle_done}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
      reset = 1'b1;
      advance();

      // Lane 1 load only, memory always ready
      clear_counts();
      lat = 1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, '0, 32'h0, '0);
      run_bundle("t1", 20);
      chk("t1_req_cnt", req_cnt, 32'd1);
      chk("t1_addr", acc_addr[0], 32'h100);
      chk("t1_we", acc_we[0], 32'd0);
      chk("t1_stall_cnt", stall_cnt, 32'd2);
      chk("t1_done_cnt", done_cnt, 32'd1);
      chk("t1_rdata1", cap_r1, 32'hDEAD_BEEF);
      chk("t1_rdata2", cap_r2, 32'd0);

      // Lane 1 store then lane 2 load, same address, 2-cycle memory
      clear_counts();
      lat = 2;
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h11, 32'h40, '0);
      run_bundle("t2", 30);
      chk("t2_acc_n", acc_n, 32'd2);
      chk("t2_first_we", acc_we[0], 32'd1);
      chk("t2_first_wdata", acc_wdata[0], 32'h11);
      chk("t2_second_we", acc_we[1], 32'd0);
      chk("t2_rdata2", cap_r2, 32'h11);
      chk("t2_rdata1", cap_r1, 32'd0);
      chk("t2_stall_cnt", stall_cnt, 32'd5);
      chk("t2_req_cnt", req_cnt, 32'd4);

      // Lane 2 store only
      clear_counts();
      lat = 1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 32'h8, 32'h5A);
      run_bundle("t3", 20);
      chk("t3_acc_n", acc_n, 32'd1);
      chk("t3_we", acc_we[0], 32'd1);
      chk("t3_addr", acc_addr[0], 32'h8);
      chk("t3_wdata", acc_wdata[0], 32'h5A);
      chk("t3_stall_cnt", stall_cnt, 32'd2);
      chk("t3_mem", mem[2], 32'h5A);

      // Two loads, no wait: three stall cycles, lane 1 first
      clear_counts();
      lat = 1;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, '0, 32'h8, '0);
      run_bundle("t4", 20);
      chk("t4_stall_cnt", stall_cnt, 32'd3);
      chk("t4_first_addr", acc_addr[0], 32'h100);
      chk("t4_second_addr", acc_addr[1], 32'h8);
      chk("t4_rdata1", cap_r1, 32'hDEAD_BEEF);
      chk("t4_rdata2", cap_r2, 32'h5A);

      // Ready arrives on the last permitted waiting cycle: no abort
      clear_counts();
      lat = 15;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, '0, '0, '0);
      run_bundle("t5", 40);
      chk("t5_req_cnt", req_cnt, 32'd15);
      chk("t5_rdata1", cap_r1, 32'hDEAD_BEEF);
      chk("t5_timeout", {31'd0, timeout_err}, 32'd0);

      // Memory never answers: abort after 15 cycles, lane 2 skipped
      clear_counts();
      lat = 0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, '0, 32'h40, '0);
      run_bundle("t6", 40);
      chk("t6_req_cnt", req_cnt, 32'd15);
      chk("t6_stall_cnt", stall_cnt, 32'd16);
      chk("t6_done_cnt", done_cnt, 32'd1);
      chk("t6_timeout", {31'd0, timeout_err}, 32'd1);
      chk("t6_rdata1", cap_r1, 32'd0);
      chk("t6_rdata2", cap_r2, 32'd0);

      // Reset in the second cycle of ACC1
      clear_counts();
      lat = 0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, '0, '0, '0);
      sample();
      advance();
      sample();
      advance();
      sample();
      chk("t7_pre_req", {31'd0, mem_req}, 32'd1);
      chk("t7_pre_timeout", {31'd0, timeout_err}, 32'd1);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      advance();
      sample();
      chk("t7_req", {31'd0, mem_req}, 32'd0);
      chk("t7_stall", {31'd0, stall}, 32'd0);
      chk("t7_we", {31'd0, mem_we}, 32'd0);
      chk("t7_addr", mem_addr, 32'd0);
      chk("t7_done", {31'd0, bundle_done}, 32'd0);
      chk("t7_timeout", {31'd0, timeout_err}, 32'd0);
      reset = 1'b1;
      advance();
      clear_counts();
      lat = 1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 32'h40, '0);
      run_bundle("t7b", 20);
      chk("t7b_rdata2", cap_r2, 32'h11);
      chk("t7b_stall_cnt", stall_cnt, 32'd2);
      chk("t7b_done_cnt", done_cnt, 32'd1);

      // Read and write both set in lane 1: treated as a store
      clear_counts();
      lat = 1;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h77, '0, '0);
      run_bundle("t8", 20);
      chk("t8_we", acc_we[0], 32'd1);
      chk("t8_wdata", acc_wdata[0], 32'h77);
      chk("t8_rdata1", cap_r1, 32'd0);

      // Valid bundle without memory ops
      clear_counts();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h1, 32'h40, 32'h2);
      for (int i = 0; i < 3; i++) begin
         sample();
         advance();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      chk("t9_stall_cnt", stall_cnt, 32'd0);
      chk("t9_req_cnt", req_cnt, 32'd0);
      chk("t9_done_cnt", done_cnt, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dual_lane_mem_sequencer.md
Name: dual_lane_mem_sequencer

Overview:
- Sits between the dual-lane EX/MEM pipeline register and the single-port data memory.
- When one issue bundle contains memory operations in both lanes, it serialises them in program order: lane 1 first (older), then lane 2.
- It holds the front of the pipeline with a stall, then presents both lanes' load data to MEM/WB together with a one-cycle done pulse.
- A watchdog aborts any access the memory never acknowledges.

Parameters:
- DATA_W, 32, data and address width.
- MAX_WAIT, 15, maximum cycles a single access may wait for mem_ready before abort (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- bundle_valid  in  1  the EX/MEM register holds a valid bundle.
- memread1, memwrite1  in  1 each  lane 1 load/store.
- memread2, memwrite2  in  1 each  lane 2 load/store.
- addr1, addr2  in  DATA_W  ALU result per lane, used as byte address.
- wdata1, wdata2  in  DATA_W  store data per lane.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr, mem_wdata  out  DATA_W  memory address and write data.
- mem_ready  in  1  access completes at this clock edge.
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
- stall  out  1  freeze PC/IF/ID/ID-EX/EX-MEM.
- bundle_done  out  1  one-cycle pulse; rdata outputs valid.
- rdata1, rdata2  out  DATA_W  load results per lane.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- States: IDLE, ACC1, ACC2, DONE. A lane "needs mem" = memread|memwrite. If both memread and memwrite are set in one lane, the access is treated as a write.
- Reset (reset=0 at a clock edge): state=IDLE; mem_req, mem_we, bundle_done, stall(registered part) = 0; mem_addr, mem_wdata, rdata1, rdata2 = 0; wait counter = 0; timeout_err = 0. Reset in mid-access abandons the access immediately, and mem_req is low on the next cycle.
- IDLE: if bundle_valid and any lane needs mem:
  - latch addr, wdata and op for both lanes, clear rdata1/rdata2 to 0;
  - go to ACC1 if lane 1 needs mem, else ACC2.
  - Otherwise remain in IDLE.
- stall is combinational: 1 when state ∈ {ACC1, ACC2}, or when state=IDLE, bundle_valid=1 and any lane needs mem. It is 0 in DONE and in an IDLE cycle with no memory op.
- ACC1/ACC2: mem_req=1, with mem_we/mem_addr/mem_wdata taken from the latched lane. These are held stable until mem_ready=1.
  - On the mem_ready edge, a load captures mem_rdata into rdata1/rdata2 (lane 1/lane 2 respectively).
  - From ACC1, next state is ACC2 if lane 2 needs mem, else DONE. From ACC2, next state is DONE.
  - Back-to-back: ACC1 completing at edge N puts ACC2 on the bus in cycle N+1. mem_req may stay high across the two accesses.
- Minimum latency: a one-access bundle with mem_ready already high occupies IDLE→ACC→DONE (2 stall cycles). Two accesses take 3 stall cycles.
- Watchdog: the counter resets to 0 on entry to each ACC state and increments every cycle mem_ready=0.
  - If mem_ready=0 when the counter equals MAX_WAIT-1 (i.e. the MAX_WAIT-th waiting cycle), the access aborts: timeout_err←1 (sticky until reset), the remaining accesses are skipped, next state is DONE, and rdata for un-completed loads stays 0.
  - mem_ready=1 on that same cycle means the access completes normally; no error.
- DONE: mem_req=0, bundle_done=1, stall=0. The pipeline advances at this edge, and bundle_valid/op inputs are ignored during DONE. Next state is IDLE unconditionally.
- rdata1/rdata2 hold their values until the next bundle is accepted or reset.
- Ordering guarantees read-after-write correctness: a lane 1 store followed by a lane 2 load to the same address returns the stored data.

Decomposition:
- Shared package (cpu_pkg): state encoding enum (IDLE=2'd0, ACC1=2'd1, ACC2=2'd2, DONE=2'd3), DATA_W default, and a lane_op struct {we, addr, wdata, need}.
- One natural sub-module: mem_wait_watchdog (counter + expiry compare, parameter MAX_WAIT, inputs clear/ready, output expire). Everything else stays in the top.

Test Plan:
- Lane 1 load addr 0x100 only, mem_ready tied 1, mem_rdata=0xDEADBEEF:
  - mem_req high for 1 cycle with addr 0x100 and we=0;
  - stall high for 2 cycles;
  - bundle_done pulse with rdata1=0xDEADBEEF, rdata2=0.
- Lane 1 store 0x40←0x11 and lane 2 load 0x40, memory model with 2-cycle ready:
  - the write is issued before the read;
  - rdata2=0x11;
  - stall spans 1+2+2 = 5 cycles.
- Lane 2 store only, addr 0x8, wdata 0x5A:
  - state goes IDLE→ACC2→DONE with no lane 1 access;
  - mem_we=1, mem_addr=0x8.
- mem_ready held low, MAX_WAIT=15:
  - mem_req high for exactly 15 cycles;
  - timeout_err rises and stays high;
  - bundle_done pulses, rdata1=0.
- reset=0 asserted in the 2nd cycle of ACC1:
  - next cycle mem_req=0, stall=0, all outputs 0, state IDLE;
  - a subsequent bundle is processed normally.
- bundle_valid=1 with no mem ops: stall stays 0, mem_req stays 0, no bundle_done.
